// File: rtl/alu_pkg.sv
// Opcode and FSM state definitions for the multi-cycle ALU.
// These are shared with the control unit.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier that processes one multiplier bit per clock.
// `product` is combinational and holds the complete result during the cycle in which `last` is high.
module alu_shift_add_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               active;

    // The add for the current step is exposed here, so the caller can capture the final product on the same edge that completes the last step.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        product  = acc_next;
        last     = active && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, multiplicand};
            mplier <= multiplier;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU. Single-cycle ops complete one edge after start.
// MUL runs for WIDTH edges and asserts busy while it runs.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow
);

    alu_state_t         state;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   op_result;
    logic               op_ovf;
    logic               mul_load;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;

    always_comb begin
        sum       = A + B;
        diff      = A - B;
        op_result = '0;
        op_ovf    = 1'b0;
        case (ALUOperation)
            OP_AND: op_result = A & B;
            OP_OR:  op_result = A | B;
            OP_NOR: op_result = ~(A | B);
            OP_XOR: op_result = A ^ B;
            OP_ADD: begin
                op_result = sum;
                op_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = diff;
                op_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: begin
                op_result = '0;
                op_ovf    = 1'b0;
            end
        endcase
    end

    assign mul_load = (state == IDLE) && start && (ALUOperation == OP_MUL);

    alu_shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk         (clk),
        .reset       (reset),
        .load        (mul_load),
        .multiplicand(A),
        .multiplier  (B),
        .product     (mul_product),
        .last        (mul_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            ResultHi  <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ALUOperation == OP_MUL) begin
                            state <= MUL_RUN;
                            busy  <= 1'b1;
                        end else begin
                            ALUResult <= op_result;
                            ResultHi  <= '0;
                            Zero      <= (op_result == '0);
                            Overflow  <= op_ovf;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        {ResultHi, ALUResult} <= mul_product;
                        Zero     <= (mul_product[WIDTH-1:0] == '0);
                        Overflow <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu that drives a 32-bit and an 8-bit instance.
// Each accepted start pushes its expected completion onto a queue, and a monitor pops and compares that entry when done is seen.
module tb_multicycle_alu;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        zero;
        logic        ovf;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start32, start8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, zero32, ovf32;
    logic        busy8, done8, zero8, ovf8;
    logic [31:0] res32, hi32;
    logic [7:0]  res8, hi8;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   done32_seen = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    vec_t vec[14];

    multicycle_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUOperation(op32),
        .A(a32), .B(b32), .busy(busy32), .done(done32), .ALUResult(res32),
        .ResultHi(hi32), .Zero(zero32), .Overflow(ovf32)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUOperation(op8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .ALUResult(res8),
        .ResultHi(hi8), .Zero(zero8), .Overflow(ovf8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (reset && done32) begin
            done32_seen++;
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                check("res32", {32'd0, res32}, e32.res);
                check("hi32", {32'd0, hi32}, e32.hi);
                check("zero32", {63'd0, zero32}, {63'd0, e32.zero});
                check("ovf32", {63'd0, ovf32}, {63'd0, e32.ovf});
                check("latency32", 64'(cyc), 64'(e32.due));
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (reset && done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                check("res8", {56'd0, res8}, e8.res);
                check("hi8", {56'd0, hi8}, e8.hi);
                check("zero8", {63'd0, zero8}, {63'd0, e8.zero});
                check("ovf8", {63'd0, ovf8}, {63'd0, e8.ovf});
                check("latency8", 64'(cyc), 64'(e8.due));
            end
        end
    end

    initial begin
        int c0;
        int seen0;
        int waited;

        vec[0]  = '{4'd3, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vec[1]  = '{4'd4, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vec[2]  = '{4'd4, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1};
        vec[3]  = '{4'd6, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vec[4]  = '{4'd6, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vec[5]  = '{4'd0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
        vec[6]  = '{4'd1, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0, 1'b0};
        vec[7]  = '{4'd2, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vec[8]  = '{4'd5, 32'hA5A5_A5A5,  32'hFFFF_FFFF,  32'h5A5A_5A5A,  1'b0, 1'b0};
        vec[9]  = '{4'd3, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vec[10] = '{4'd3, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vec[11] = '{4'd4, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vec[12] = '{4'd15, 32'h0000_FFFF, 32'h0000_FFFF,  32'd0,          1'b1, 1'b0};
        vec[13] = '{4'd8, 32'h1234_5678,  32'h0000_0001,  32'd0,          1'b1, 1'b0};

        reset = 1'b0;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;

        @(negedge clk);
        check("rst_busy", {63'd0, busy32}, 64'd0);
        check("rst_done", {63'd0, done32}, 64'd0);
        check("rst_res", {32'd0, res32}, 64'd0);
        check("rst_hi", {32'd0, hi32}, 64'd0);
        check("rst_zero", {63'd0, zero32}, 64'd1);
        check("rst_ovf", {63'd0, ovf32}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle operations from the table
        for (int i = 0; i < 14; i++) begin
            start32 = 1'b1;
            op32 = vec[i].op;
            a32 = vec[i].a;
            b32 = vec[i].b;
            q32.push_back('{res: {32'd0, vec[i].res}, hi: 64'd0, zero: vec[i].zero,
                            ovf: vec[i].ovf, due: cyc + 1});
            @(negedge clk);
        end
        start32 = 1'b0;
        repeat (2) @(negedge clk);

        // 32-bit MUL with an ignored ADD start while busy
        start32 = 1'b1; op32 = 4'd7; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        c0 = cyc;
        q32.push_back('{res: 64'h1, hi: 64'hFFFF_FFFE, zero: 1'b0, ovf: 1'b0, due: c0 + 33});
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        check("mul32_busy_start", {63'd0, busy32}, 64'd1);
        repeat (4) @(negedge clk);
        start32 = 1'b1; op32 = 4'd3; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        start32 = 1'b0;
        while (cyc < c0 + 32) @(negedge clk);
        check("mul32_busy_last", {63'd0, busy32}, 64'd1);
        @(negedge clk);
        check("mul32_busy_end", {63'd0, busy32}, 64'd0);
        check("mul32_done_end", {63'd0, done32}, 64'd1);
        repeat (2) @(negedge clk);

        // 8-bit MUL followed immediately by an ADD in the done cycle
        start8 = 1'b1; op8 = 4'd7; a8 = 8'd200; b8 = 8'd3;
        c0 = cyc;
        q8.push_back('{res: 64'h58, hi: 64'h02, zero: 1'b0, ovf: 1'b0, due: c0 + 9});
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
        while (cyc < c0 + 9) @(negedge clk);
        check("mul8_done", {63'd0, done8}, 64'd1);
        check("mul8_busy", {63'd0, busy8}, 64'd0);
        start8 = 1'b1; op8 = 4'd3; a8 = 8'h80; b8 = 8'h80;
        q8.push_back('{res: 64'h0, hi: 64'h0, zero: 1'b1, ovf: 1'b1, due: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a MUL
        start32 = 1'b1; op32 = 4'd7; a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {63'd0, busy32}, 64'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy32}, 64'd0);
        check("abort_done", {63'd0, done32}, 64'd0);
        check("abort_res", {32'd0, res32}, 64'd0);
        check("abort_hi", {32'd0, hi32}, 64'd0);
        check("abort_zero", {63'd0, zero32}, 64'd1);
        check("abort_ovf", {63'd0, ovf32}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen0 = done32_seen;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done32_seen - seen0), 64'd0);

        start32 = 1'b1; op32 = 4'd3; a32 = 32'd1; b32 = 32'd1;
        q32.push_back('{res: 64'd2, hi: 64'd0, zero: 1'b0, ovf: 1'b0, due: cyc + 1});
        @(negedge clk);
        start32 = 1'b0;

        waited = 0;
        while ((q32.size() != 0 || q8.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", 64'(q32.size() + q8.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
